// File: rtl/master_0_b2p_channel_filter.sv
// Channel filter for a byte stream: forwards packets of ACCEPT_CHANNEL, drops the rest.
// Latency: 1 cycle from acceptance to out_* when the 2-entry output FIFO is empty.
// Backpressure: in_ready falls while the FIFO holds 2 beats; dropped beats also wait for in_ready.
//
// Ports:
//   clk, reset           - single rising-edge clock, synchronous active-high reset
//   in_*                 - channelized valid/ready input stream (in_channel sampled on SOP only)
//   out_*                - filtered valid/ready output stream, driven from the FIFO head
//   drop_count           - number of dropped packets, saturating at 16'hFFFF
//   protocol_error       - one-cycle pulse the cycle after a framing violation is accepted
module master_0_b2p_channel_filter #(
   parameter int ACCEPT_CHANNEL = 0,
   parameter int CHANNEL_WIDTH  = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     in_ready,
   input  logic                     in_valid,
   input  logic [7:0]               in_data,
   input  logic                     in_startofpacket,
   input  logic                     in_endofpacket,
   input  logic [CHANNEL_WIDTH-1:0] in_channel,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [7:0]               out_data,
   output logic                     out_startofpacket,
   output logic                     out_endofpacket,
   output logic [15:0]              drop_count,
   output logic                     protocol_error
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PASS = 2'd1,
      DROP = 2'd2
   } state_t;

   typedef struct packed {
      logic [7:0] data;
      logic       sop;
      logic       eop;
   } beat_t;

   localparam logic [CHANNEL_WIDTH-1:0] MATCH_CHANNEL = CHANNEL_WIDTH'(ACCEPT_CHANNEL);

   state_t      state;
   state_t      state_next;

   beat_t       fifo_mem [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  fill;

   logic        accept;
   logic        pop;
   logic        push;
   logic        drop_pkt;
   logic        frame_err;

   logic [15:0] drop_cnt;
   logic        perr_q;

   // Gating with reset keeps the source stalled during reset without waiting
   // for the registered fill to clear.
   assign in_ready  = !reset && (fill != 2'd2);
   assign accept    = in_valid && in_ready;
   assign out_valid = (fill != 2'd0);
   assign pop       = out_valid && out_ready;

   assign out_data          = fifo_mem[rd_ptr].data;
   assign out_startofpacket = fifo_mem[rd_ptr].sop;
   assign out_endofpacket   = fifo_mem[rd_ptr].eop;

   assign drop_count     = drop_cnt;
   assign protocol_error = perr_q;

   // Packet framing FSM. Only accepted beats move it. An SOP seen mid-packet
   // flags an error and then restarts filtering on the new SOP; the truncated
   // packet is left without an EOP on purpose.
   always_comb begin
      state_next = state;
      push       = 1'b0;
      drop_pkt   = 1'b0;
      frame_err  = 1'b0;

      if (accept) begin
         if (in_startofpacket) begin
            if (state != IDLE) begin
               frame_err = 1'b1;
            end
            if (in_channel == MATCH_CHANNEL) begin
               push       = 1'b1;
               state_next = in_endofpacket ? IDLE : PASS;
            end else begin
               drop_pkt   = 1'b1;
               state_next = in_endofpacket ? IDLE : DROP;
            end
         end else begin
            unique case (state)
               IDLE: begin
                  // Stray continuation beat: no packet is open, discard it.
                  frame_err = 1'b1;
               end
               PASS: begin
                  // Channel is only meaningful on SOP; continuation beats follow the packet.
                  push = 1'b1;
                  if (in_endofpacket) begin
                     state_next = IDLE;
                  end
               end
               DROP: begin
                  if (in_endofpacket) begin
                     state_next = IDLE;
                  end
               end
               default: begin
                  state_next = IDLE;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         fill        <= 2'd0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
         drop_cnt    <= 16'd0;
         perr_q      <= 1'b0;
      end else begin
         state  <= state_next;
         perr_q <= frame_err;

         // push only happens with in_ready high, so the FIFO can never overflow.
         if (push) begin
            fifo_mem[wr_ptr] <= '{data: in_data, sop: in_startofpacket, eop: in_endofpacket};
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end

         unique case ({push, pop})
            2'b10:   fill <= fill + 2'd1;
            2'b01:   fill <= fill - 2'd1;
            default: fill <= fill;
         endcase

         if (drop_pkt && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end

endmodule
